frame_buffer_sram_port: RTL and testbench

- Responder end of the burst-write interface used by the font and graphics writers (ReqBurstWrite / AddrValid / WrAddress / WrData).
- Arbitrates that write client against the display fetch read client.
- Drives the external asynchronous 16-bit SRAM frame buffer, one word per access.
- Sits between the drawing writers and the SRAM pins; the display scan-out logic is its read client.

---
 rtl/frame_buffer_sram_port.sv | 174 +++++++++++++++++
 tb/tb_frame_buffer_sram_port.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_sram_port.sv
// frame_buffer_sram_port
//   Connects the drawing writers (burst-write client) and the display fetch (read client) to an
//   external asynchronous 16-bit SRAM frame buffer. Each access moves one word. Every access
//   returns to StIdle, and the two clients are arbitrated there.
//
// Ports
//   Clock, Reset              system clock, synchronous active-high reset
//   ReqBurstWrite             write client request, held for the whole burst
//   WrAddress, WrData         current write word
//   AddrValid                 pulse: write word consumed; next word is expected on the next cycle
//   RdReq, RdAddress          display read request (level) and word address
//   RdAck                     pulse: RdAddress consumed
//   RdData, RdDataValid       read result and one-cycle qualifier
//   SramAddr, SramDQ_o        registered SRAM address and write data
//   SramDQ_oe                 DQ pad output enable
//   SramDQ_i                  SRAM read data
//   SramCE_n/OE_n/WE_n        registered active-low SRAM strobes
module frame_buffer_sram_port #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned WE_PULSE   = 1,
  parameter int unsigned RD_CYCLES  = 2,
  parameter int unsigned MAX_RD_RUN = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqBurstWrite,
  input  logic [ADDR_W-1:0] WrAddress,
  input  logic [DATA_W-1:0] WrData,
  output logic              AddrValid,
  input  logic              RdReq,
  input  logic [ADDR_W-1:0] RdAddress,
  output logic              RdAck,
  output logic [DATA_W-1:0] RdData,
  output logic              RdDataValid,
  output logic [ADDR_W-1:0] SramAddr,
  output logic [DATA_W-1:0] SramDQ_o,
  output logic              SramDQ_oe,
  input  logic [DATA_W-1:0] SramDQ_i,
  output logic              SramCE_n,
  output logic              SramOE_n,
  output logic              SramWE_n
);

  localparam int unsigned CntMax = (RD_CYCLES > WE_PULSE) ? RD_CYCLES : WE_PULSE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RunW   = $clog2(MAX_RD_RUN + 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrSetup, StWrPulse} stateT;

  stateT             stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;
  logic [RunW-1:0]   runQ, runD;
  logic              readTurnQ, readTurnD;
  logic [ADDR_W-1:0] addrD;
  logic [DATA_W-1:0] dqOD, rdDataD;
  logic              dqOeD, ceD, oeD, weD, rdValidD;
  logic              grantRd, grantWr, runAtMax;

  assign runAtMax  = (runQ >= RunW'(MAX_RD_RUN));
  assign AddrValid = grantWr;
  assign RdAck     = grantRd;

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    runD      = runQ;
    readTurnD = 1'b0;
    addrD     = SramAddr;
    dqOD      = SramDQ_o;
    dqOeD     = SramDQ_oe;
    ceD       = SramCE_n;
    oeD       = SramOE_n;
    weD       = SramWE_n;
    rdDataD   = RdData;
    rdValidD  = 1'b0;
    grantRd   = 1'b0;
    grantWr   = 1'b0;

    unique case (stateQ)
      StIdle: begin
        // Write data is held on the pads for one idle cycle after WE_n rises, then released.
        dqOeD = 1'b0;
        // The idle cycle right after a read is dead, so the SRAM has released DQ before the
        // next access. Reads from a held request therefore repeat every RD_CYCLES+2 cycles.
        if (!Reset && !readTurnQ) begin
          if (RdReq && !(ReqBurstWrite && runAtMax)) begin
            grantRd = 1'b1;
          end else if (ReqBurstWrite) begin
            grantWr = 1'b1;
          end
        end
        if (grantRd) begin
          stateD = StRdWait;
          cntD   = CntW'(RD_CYCLES - 1);
          addrD  = RdAddress;
          ceD    = 1'b0;
          oeD    = 1'b0;
        end
        if (grantWr) begin
          stateD = StWrSetup;
          addrD  = WrAddress;
          dqOD   = WrData;
          dqOeD  = 1'b1;
          ceD    = 1'b0;
        end
      end
      StRdWait: begin
        if (cntQ == '0) begin
          rdDataD   = SramDQ_i;
          rdValidD  = 1'b1;
          oeD       = 1'b1;
          ceD       = 1'b1;
          readTurnD = 1'b1;
          stateD    = StIdle;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      StWrSetup: begin
        weD    = 1'b0;
        cntD   = CntW'(WE_PULSE - 1);
        stateD = StWrPulse;
      end
      StWrPulse: begin
        if (cntQ == '0) begin
          weD    = 1'b1;
          ceD    = 1'b1;
          stateD = StIdle;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
    endcase

    // Read run length only matters while a write is waiting.
    if (!ReqBurstWrite || grantWr) begin
      runD = '0;
    end else if (grantRd && !runAtMax) begin
      runD = runQ + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ      <= StIdle;
      cntQ        <= '0;
      runQ        <= '0;
      readTurnQ   <= 1'b0;
      SramAddr    <= '0;
      SramDQ_o    <= '0;
      SramDQ_oe   <= 1'b0;
      SramCE_n    <= 1'b1;
      SramOE_n    <= 1'b1;
      SramWE_n    <= 1'b1;
      RdData      <= '0;
      RdDataValid <= 1'b0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      runQ        <= runD;
      readTurnQ   <= readTurnD;
      SramAddr    <= addrD;
      SramDQ_o    <= dqOD;
      SramDQ_oe   <= dqOeD;
      SramCE_n    <= ceD;
      SramOE_n    <= oeD;
      SramWE_n    <= weD;
      RdData      <= rdDataD;
      RdDataValid <= rdValidD;
    end
  end

endmodule

// File: tb/tb_frame_buffer_sram_port.sv
// tb_frame_buffer_sram_port
//   Self-checking bench for frame_buffer_sram_port. A behavioural SRAM sits on the pins. A
//   monitor keeps a reference memory and scoreboard queues: write words are queued on AddrValid
//   and compared at the first WE_n-low cycle, and read results are queued on RdAck and compared
//   on RdDataValid. A second instance with WE_PULSE=3 is used for the mid-pulse reset case.
module tb_frame_buffer_sram_port;
  localparam int unsigned AddrW = 18;
  localparam int unsigned DataW = 16;
  localparam time ClkPeriod = 10;

  logic Clock = 1'b0;
  always #(ClkPeriod / 2) Clock = ~Clock;

  logic             Reset, ReqBurstWrite, RdReq;
  logic [AddrW-1:0] WrAddress, RdAddress;
  logic [DataW-1:0] WrData;
  logic             AddrValid, RdAck, RdDataValid, SramDQ_oe, SramCE_n, SramOE_n, SramWE_n;
  logic [DataW-1:0] RdData, SramDQ_o, SramDQ_i;
  logic [AddrW-1:0] SramAddr;

  logic             av3, rdAck3, rdv3, dqOe3, ce3, oe3, we3;
  logic [DataW-1:0] rdData3, dqO3;
  logic [AddrW-1:0] sramAddr3;

  frame_buffer_sram_port dut (
    .Clock(Clock), .Reset(Reset), .ReqBurstWrite(ReqBurstWrite), .WrAddress(WrAddress),
    .WrData(WrData), .AddrValid(AddrValid), .RdReq(RdReq), .RdAddress(RdAddress), .RdAck(RdAck),
    .RdData(RdData), .RdDataValid(RdDataValid), .SramAddr(SramAddr), .SramDQ_o(SramDQ_o),
    .SramDQ_oe(SramDQ_oe), .SramDQ_i(SramDQ_i), .SramCE_n(SramCE_n), .SramOE_n(SramOE_n),
    .SramWE_n(SramWE_n)
  );

  frame_buffer_sram_port #(.WE_PULSE(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .ReqBurstWrite(ReqBurstWrite), .WrAddress(WrAddress),
    .WrData(WrData), .AddrValid(av3), .RdReq(RdReq), .RdAddress(RdAddress), .RdAck(rdAck3),
    .RdData(rdData3), .RdDataValid(rdv3), .SramAddr(sramAddr3), .SramDQ_o(dqO3),
    .SramDQ_oe(dqOe3), .SramDQ_i(SramDQ_i), .SramCE_n(ce3), .SramOE_n(oe3), .SramWE_n(we3)
  );

  // Behavioural SRAM for the main instance, with a bench-side preload port.
  logic [DataW-1:0] mem    [0:(1<<AddrW)-1];
  logic [DataW-1:0] refMem [0:(1<<AddrW)-1];
  logic             preEn;
  logic [AddrW-1:0] preAddr;
  logic [DataW-1:0] preData;

  always @(posedge Clock) begin
    if (preEn) mem[preAddr] <= preData;
    else if (!SramCE_n && !SramWE_n) mem[SramAddr] <= SramDQ_o;
  end
  assign SramDQ_i = (!SramCE_n && !SramOE_n) ? mem[SramAddr] : '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard state.
  logic [AddrW+DataW-1:0] wrQ[$];
  logic [DataW-1:0]       rdQ[$];
  bit                     grantLog[$];
  bit                     logEn = 1'b0;
  bit                     armed = 1'b0;
  int                     avCount = 0, ackCount = 0, weLowCount = 0;

  initial begin : monitor
    logic [AddrW+DataW-1:0] e;
    logic                   prevWeLow = 1'b0, prevWeLow3 = 1'b0;
    logic [AddrW-1:0]       prevAddr3 = '0;
    logic [DataW-1:0]       prevDq3 = '0;
    forever begin
      @(negedge Clock);
      if (preEn) refMem[preAddr] = preData;
      if (armed && !Reset) begin
        assert (!(!SramOE_n && SramDQ_oe)) else begin
          errors++; $display("FAIL inv_oe_dqoe: OE_n=0 with DQ_oe=1, required DQ_oe=0");
        end
        assert (!(!SramOE_n && !SramWE_n)) else begin
          errors++; $display("FAIL inv_oe_we: OE_n=0 with WE_n=0, required WE_n=1");
        end
        assert (!(AddrValid && RdAck)) else begin
          errors++; $display("FAIL inv_grants: AddrValid=1 with RdAck=1, required one-hot");
        end
        assert (!(!oe3 && (dqOe3 || !we3))) else begin
          errors++; $display("FAIL inv3_oe: OE_n=0 DQ_oe=%0b WE_n=%0b, required 0/1", dqOe3, we3);
        end
        assert (!(prevWeLow3 && !we3 && (sramAddr3 != prevAddr3 || dqO3 != prevDq3))) else begin
          errors++;
          $display("FAIL inv3_stable: addr 0x%0h data 0x%0h, required 0x%0h 0x%0h",
                   sramAddr3, dqO3, prevAddr3, prevDq3);
        end
      end
      if (AddrValid) begin
        avCount++;
        refMem[WrAddress] = WrData;
        wrQ.push_back({WrAddress, WrData});
        if (logEn) grantLog.push_back(1'b1);
      end
      if (RdAck) begin
        ackCount++;
        rdQ.push_back(refMem[RdAddress]);
        if (logEn) grantLog.push_back(1'b0);
      end
      if (!SramWE_n) begin
        weLowCount++;
        if (!prevWeLow) begin
          if (wrQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: WE pulse at 0x%0h, required no pulse", SramAddr);
          end else begin
            e = wrQ.pop_front();
            check("wr_sram_addr", 32'(SramAddr), 32'(e[AddrW+DataW-1:DataW]));
            check("wr_sram_data", 32'(SramDQ_o), 32'(e[DataW-1:0]));
          end
        end
      end
      if (RdDataValid) begin
        if (rdQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: RdDataValid with data 0x%0h, required none", RdData);
        end else begin
          check("rd_data", 32'(RdData), 32'(rdQ.pop_front()));
        end
      end
      prevWeLow  = !SramWE_n;
      prevWeLow3 = !we3;
      prevAddr3  = sramAddr3;
      prevDq3    = dqO3;
    end
  end

  initial begin : watchdog
    #(ClkPeriod * 20000);
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  // sel: 0 AddrValid, 1 RdAck, 2 AddrValid of the WE_PULSE=3 instance
  task automatic waitFor(input int sel, output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      if ((sel == 0 && AddrValid) || (sel == 1 && RdAck) || (sel == 2 && av3)) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_timeout", 32'(got), 32'd1);
  endtask

  task automatic preloadWord(input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
    nextCycle();
    preEn = 1'b1; preAddr = a; preData = d;
    nextCycle();
    preEn = 1'b0;
  endtask

  typedef struct {
    bit               isWr;
    bit               preload;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    int               expLat;   // write: grant to first idle cycle; read: RdAck to RdDataValid
    int               expLow;   // cycles WE_n (write) or OE_n (read) is low
  } vecT;

  task automatic runVec(input vecT v);
    bit got;
    int lat = 0, low = 0, av0 = avCount, ack0 = ackCount;
    if (v.preload) preloadWord(v.addr, v.data);
    nextCycle();
    if (v.isWr) begin
      ReqBurstWrite = 1'b1; WrAddress = v.addr; WrData = v.data;
    end else begin
      RdReq = 1'b1; RdAddress = v.addr;
    end
    waitFor(v.isWr ? 0 : 1, got);
    nextCycle();
    ReqBurstWrite = 1'b0; RdReq = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (v.isWr) begin
        if (!SramWE_n) low++;
        if (k == 1) begin
          check("wr_setup_addr", 32'(SramAddr), 32'(v.addr));
          check("wr_setup_data", 32'(SramDQ_o), 32'(v.data));
          check("wr_setup_we", 32'(SramWE_n), 32'd1);
          check("wr_setup_ce", 32'(SramCE_n), 32'd0);
        end
        if (lat == 0 && k > 1 && SramCE_n) lat = k;
        if (k == v.expLat) check("wr_dqoe_hold", 32'(SramDQ_oe), 32'd1);
        if (k == v.expLat + 1) check("wr_dqoe_drop", 32'(SramDQ_oe), 32'd0);
      end else begin
        if (!SramOE_n) low++;
        if (RdDataValid) lat = k;
      end
    end
    check(v.isWr ? "wr_latency" : "rd_latency", 32'(lat), 32'(v.expLat));
    check(v.isWr ? "wr_we_low" : "rd_oe_low", 32'(low), 32'(v.expLow));
    check("one_pulse", 32'(v.isWr ? avCount - av0 : ackCount - ack0), 32'd1);
  endtask

  initial begin : test
    vecT              vecs[7];
    bit               got;
    time              tPrev, tNow;
    time              acks[$];
    int               wcount, lowCnt, we0;
    logic [AddrW-1:0] a;

    vecs[0] = '{1'b1, 1'b0, 18'h12345, 16'h7FFF, 3, 1};
    vecs[1] = '{1'b0, 1'b1, 18'h00100, 16'hA5A5, 3, 2};
    vecs[2] = '{1'b1, 1'b0, 18'h00000, 16'h0000, 3, 1};
    vecs[3] = '{1'b0, 1'b0, 18'h12345, 16'h0000, 3, 2};
    vecs[4] = '{1'b1, 1'b0, 18'h3FFFF, 16'hFFFF, 3, 1};
    vecs[5] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 3, 2};
    vecs[6] = '{1'b0, 1'b0, 18'h00000, 16'h0000, 3, 2};

    Reset = 1'b1; ReqBurstWrite = 1'b0; RdReq = 1'b0;
    WrAddress = '0; WrData = '0; RdAddress = '0;
    preEn = 1'b0; preAddr = '0; preData = '0;
    nextCycle();
    nextCycle();
    @(negedge Clock);
    check("rst_addrvalid", 32'(AddrValid), 32'd0);
    check("rst_rdack", 32'(RdAck), 32'd0);
    check("rst_rdvalid", 32'(RdDataValid), 32'd0);
    check("rst_rddata", 32'(RdData), 32'd0);
    check("rst_sramaddr", 32'(SramAddr), 32'd0);
    check("rst_dq_o", 32'(SramDQ_o), 32'd0);
    check("rst_dq_oe", 32'(SramDQ_oe), 32'd0);
    check("rst_ce", 32'(SramCE_n), 32'd1);
    check("rst_oe", 32'(SramOE_n), 32'd1);
    check("rst_we", 32'(SramWE_n), 32'd1);
    nextCycle();
    Reset = 1'b0;
    armed = 1'b1;

    for (int i = 0; i < 7; i++) runVec(vecs[i]);

    // Burst of 7 words, one AddrValid every WE_PULSE+2 cycles.
    we0 = weLowCount;
    nextCycle();
    ReqBurstWrite = 1'b1; WrAddress = 18'h00200; WrData = 16'h0000;
    tPrev = 0;
    for (int i = 0; i < 7; i++) begin
      waitFor(0, got);
      tNow = $time;
      if (i > 0) check("burst_interval", 32'((tNow - tPrev) / ClkPeriod), 32'd3);
      tPrev = tNow;
      nextCycle();
      if (i < 6) begin
        WrAddress = 18'h00200 + 18'(i + 1);
        WrData = ((i + 1) % 2 == 1) ? 16'h7FFF : 16'h0000;
      end else begin
        ReqBurstWrite = 1'b0;
      end
    end
    repeat (10) nextCycle();
    check("burst_we_pulses", 32'(weLowCount - we0), 32'd7);
    for (int i = 0; i < 7; i++) begin
      a = 18'h00200 + 18'(i);
      check("burst_mem", 32'(mem[a]), (i % 2 == 1) ? 32'h7FFF : 32'h0000);
    end

    // Contention: 8 read grants then 1 write grant, repeating.
    grantLog.delete();
    logEn = 1'b1;
    wcount = 0;
    RdReq = 1'b1; RdAddress = 18'h00100;
    ReqBurstWrite = 1'b1; WrAddress = 18'h00300; WrData = 16'h0000;
    for (int c = 0; c < 130; c++) begin
      @(negedge Clock);
      got = AddrValid;
      nextCycle();
      if (got) begin
        wcount++;
        WrAddress = 18'h00300 + 18'(wcount);
        WrData = 16'(wcount);
      end
    end
    RdReq = 1'b0; ReqBurstWrite = 1'b0;
    repeat (12) nextCycle();
    logEn = 1'b0;
    check("contention_grants", 32'(grantLog.size() >= 27), 32'd1);
    for (int i = 0; i < 27 && i < grantLog.size(); i++) begin
      check("contention_pattern", 32'(grantLog[i]), 32'(i % 9 == 8));
    end

    // Reads alone are granted without bound, every RD_CYCLES+2 cycles.
    RdReq = 1'b1; RdAddress = 18'h00100;
    for (int c = 0; c < 45; c++) begin
      @(negedge Clock);
      if (RdAck) acks.push_back($time);
    end
    nextCycle();
    RdReq = 1'b0;
    repeat (8) nextCycle();
    check("unbounded_reads", 32'(acks.size()), 32'd12);
    for (int i = 1; i < acks.size(); i++) begin
      check("read_regrant_period", 32'((acks[i] - acks[i-1]) / ClkPeriod), 32'd4);
    end

    // Reset in the middle of a WE_PULSE=3 write.
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
    nextCycle();
    ReqBurstWrite = 1'b1; WrAddress = 18'h0ABCD; WrData = 16'h1234;
    waitFor(2, got);
    nextCycle();
    ReqBurstWrite = 1'b0;
    @(negedge Clock);
    check("rst3_setup_we", 32'(we3), 32'd1);
    nextCycle();
    @(negedge Clock);
    check("rst3_pulse_we", 32'(we3), 32'd0);
    nextCycle();
    Reset = 1'b1; ReqBurstWrite = 1'b1;
    @(negedge Clock);
    check("rst3_mid_we", 32'(we3), 32'd0);
    check("rst3_no_av", 32'(av3), 32'd0);
    check("rst_no_av_main", 32'(AddrValid), 32'd0);
    nextCycle();
    Reset = 1'b0; ReqBurstWrite = 1'b0;
    @(negedge Clock);
    check("rst3_we", 32'(we3), 32'd1);
    check("rst3_dq_oe", 32'(dqOe3), 32'd0);
    check("rst3_ce", 32'(ce3), 32'd1);
    check("rst3_oe", 32'(oe3), 32'd1);
    check("rst3_av", 32'(av3), 32'd0);
    check("rst3_rdvalid", 32'(rdv3), 32'd0);
    check("rst3_rddata", 32'(rdData3), 32'd0);
    check("rst3_addr", 32'(sramAddr3), 32'd0);
    check("rst3_dq_o", 32'(dqO3), 32'd0);
    nextCycle();
    ReqBurstWrite = 1'b1; WrAddress = 18'h0ABCE; WrData = 16'h4321;
    @(negedge Clock);
    check("rst3_new_av", 32'(av3), 32'd1);
    nextCycle();
    ReqBurstWrite = 1'b0;
    lowCnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clock);
      if (!we3) begin
        lowCnt++;
        if (lowCnt == 1) begin
          check("rst3_new_addr", 32'(sramAddr3), 32'h0ABCE);
          check("rst3_new_data", 32'(dqO3), 32'h4321);
        end
      end
    end
    check("rst3_new_we_len", 32'(lowCnt), 32'd3);

    repeat (10) nextCycle();
    check("wr_queue_drained", 32'(wrQ.size()), 32'd0);
    check("rd_queue_drained", 32'(rdQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
